// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   Bank of CHANNELS independent bus-mapped timers. Each channel has a private
//   prescaler that produces one count tick every TICK_LEN clocks while the
//   channel is enabled. On each tick the channel counter either advances or,
//   when it reaches LIM-1, wraps to 0 and raises a terminal event.
//
//   Per-channel register map (byte addresses, channel n):
//     BASE+16n+0  CNT   current count (read clears ready)
//     BASE+16n+4  LIM   period limit (0 means a full 2^BITS period)
//     BASE+16n+8  CTRL  [0] ready (RO), [2] overrun, [4] en, [5] oneshot,
//                       [8] ie; all other bits read 0
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : asynchronous active-low reset
//   we, re     : bus write / read strobes (a write masks a read)
//   memAddr    : bus byte address
//   dataBusIn  : write data
//   dataBusOut : combinational read data, zero when no decoded read
//   irq        : OR over channels of (ready & ie), combinational
// -----------------------------------------------------------------------------
module multi_timer #(
    parameter int BITS     = 32,
    parameter int BASE     = 32'h100,
    parameter int CHANNELS = 4,
    parameter int TICK_LEN = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            irq
);

    // A single-cycle tick period still needs a one-bit prescaler register.
    localparam int            PW       = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_LEN - 1);

    logic [CHANNELS*BITS-1:0] rdFlat_s;
    logic [CHANNELS-1:0]      irqCh_s;

    for (genvar n = 0; n < CHANNELS; n++) begin : gCh
        localparam logic [BITS-1:0] ADDR_CNT  = BITS'(BASE + 32'd16 * n);
        localparam logic [BITS-1:0] ADDR_LIM  = BITS'(BASE + 32'd16 * n + 32'd4);
        localparam logic [BITS-1:0] ADDR_CTRL = BITS'(BASE + 32'd16 * n + 32'd8);

        logic [BITS-1:0] cnt_r;
        logic [BITS-1:0] lim_r;
        logic [PW-1:0]   pre_r;
        logic            ready_r;
        logic            overrun_r;
        logic            en_r;
        logic            oneshot_r;
        logic            ie_r;

        logic            cntWr_s;
        logic            limWr_s;
        logic            ctrlWr_s;
        logic            cntRd_s;
        logic            limRd_s;
        logic            ctrlRd_s;
        logic            tick_s;
        logic            term_s;
        logic [BITS-1:0] ctrlVal_s;
        logic [BITS-1:0] rdData_s;

        // Address decode, tick detection and terminal compare for this channel.
        always_comb begin
            cntWr_s  = we && (memAddr == ADDR_CNT);
            limWr_s  = we && (memAddr == ADDR_LIM);
            ctrlWr_s = we && (memAddr == ADDR_CTRL);
            cntRd_s  = re && !we && (memAddr == ADDR_CNT);
            limRd_s  = re && !we && (memAddr == ADDR_LIM);
            ctrlRd_s = re && !we && (memAddr == ADDR_CTRL);
            // A CNT write suppresses the tick of that cycle entirely.
            tick_s   = en_r && (pre_r == PRE_LAST) && !cntWr_s;
            // LIM-1 wraps naturally, so LIM=0 compares against all ones.
            term_s   = tick_s && (cnt_r == (lim_r - BITS'(1)));
        end

        // Prescaler and counter: a CNT write reloads the count and restarts
        // the prescaler; otherwise both advance only while enabled.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_r <= '0;
                pre_r <= '0;
            end else if (cntWr_s) begin
                cnt_r <= dataBusIn;
                pre_r <= '0;
            end else if (en_r) begin
                if (pre_r == PRE_LAST) begin
                    pre_r <= '0;
                end else begin
                    pre_r <= pre_r + PW'(1);
                end
                if (tick_s) begin
                    cnt_r <= term_s ? '0 : (cnt_r + BITS'(1));
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= cnt_r;
                pre_r <= pre_r;
            end
        end

        // Limit register, plain software load.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lim_r <= '0;
            end else if (limWr_s) begin
                lim_r <= dataBusIn;
            end else begin
                lim_r <= lim_r;
            end
        end

        // Control/status bits. Hardware events take priority over the
        // software clear paths that coincide with them.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ready_r   <= 1'b0;
                overrun_r <= 1'b0;
                en_r      <= 1'b0;
                oneshot_r <= 1'b0;
                ie_r      <= 1'b0;
            end else begin
                if (term_s) begin
                    ready_r <= 1'b1;
                end else if (cntRd_s) begin
                    ready_r <= 1'b0;
                end else begin
                    ready_r <= ready_r;
                end

                // Overrun means a second terminal event before software
                // consumed the first one via a CNT read.
                if (term_s && ready_r) begin
                    overrun_r <= 1'b1;
                end else if (ctrlWr_s && !dataBusIn[2]) begin
                    overrun_r <= 1'b0;
                end else begin
                    overrun_r <= overrun_r;
                end

                if (term_s && oneshot_r) begin
                    en_r <= 1'b0;
                end else if (ctrlWr_s) begin
                    en_r <= dataBusIn[4];
                end else begin
                    en_r <= en_r;
                end

                if (ctrlWr_s) begin
                    oneshot_r <= dataBusIn[5];
                    ie_r      <= dataBusIn[8];
                end else begin
                    oneshot_r <= oneshot_r;
                    ie_r      <= ie_r;
                end
            end
        end

        // Read-data selection for this channel; zero unless addressed.
        always_comb begin
            ctrlVal_s    = '0;
            ctrlVal_s[0] = ready_r;
            ctrlVal_s[2] = overrun_r;
            ctrlVal_s[4] = en_r;
            ctrlVal_s[5] = oneshot_r;
            ctrlVal_s[8] = ie_r;
            if (cntRd_s) begin
                rdData_s = cnt_r;
            end else if (limRd_s) begin
                rdData_s = lim_r;
            end else if (ctrlRd_s) begin
                rdData_s = ctrlVal_s;
            end else begin
                rdData_s = '0;
            end
        end

        assign rdFlat_s[n*BITS +: BITS] = rdData_s;
        assign irqCh_s[n]               = ready_r && ie_r;
    end

    // Channel read data are mutually exclusive, so an OR merge is enough.
    always_comb begin
        dataBusOut = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            dataBusOut = dataBusOut | rdFlat_s[i*BITS +: BITS];
        end
        irq = |irqCh_s;
    end

endmodule
